// File: rtl/seq_matmul_acc.sv
// seq_matmul_acc
//   Sequential matrix multiply-accumulate engine:
//     D[M][N] = A[M][K] x B[K][N] + C[M][N]
//   One reduction step (all M*N products for a single k) per clock.
//   With accumulate_i=1 the previous result D is used as the addend
//   instead of C_mul, which supports K-tiled workloads.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   A_mul        signed [MAX_WIDTH-1:0] [M][K] left operand
//   B_mul        signed [MAX_WIDTH-1:0] [K][N] right operand
//   C_mul        signed [ACC_WIDTH-1:0] [M][N] addend
//   bitSizeA     effective precision of A elements (0 or >MAX_WIDTH = full)
//   bitSizeB     effective precision of B elements (0 or >MAX_WIDTH = full)
//   accumulate_i 1 = add into previous D, C_mul ignored
//   valid_in     request valid
//   ready_in     block can accept (IDLE and out of reset)
//   D            registered result
//   valid_out    D valid (DONE state)
//   ready_out    downstream accepts D
module seq_matmul_acc #(
  parameter int M         = 2,
  parameter int K         = 2,
  parameter int N         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SW        = $clog2(MAX_WIDTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic signed [MAX_WIDTH-1:0] A_mul [M][K],
  input  logic signed [MAX_WIDTH-1:0] B_mul [K][N],
  input  logic signed [ACC_WIDTH-1:0] C_mul [M][N],
  input  logic        [SW-1:0]        bitSizeA,
  input  logic        [SW-1:0]        bitSizeB,
  input  logic                        accumulate_i,
  input  logic                        valid_in,
  output logic                        ready_in,
  output logic signed [ACC_WIDTH-1:0] D [M][N],
  output logic                        valid_out,
  input  logic                        ready_out
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * MAX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t                      state_q, state_d;
  logic        [KW-1:0]        k_q, k_d;
  logic signed [MAX_WIDTH-1:0] a_q   [M][K];
  logic signed [MAX_WIDTH-1:0] b_q   [K][N];
  logic signed [ACC_WIDTH-1:0] acc_q [M][N];
  logic signed [ACC_WIDTH-1:0] acc_d [M][N];
  logic signed [ACC_WIDTH-1:0] d_q   [M][N];

  logic accept;
  logic last_step;

  // Keep bits [b-1:0] of x and sign-extend from bit b-1. A precision of 0
  // or wider than the stored operand means "use the full stored width".
  // Implemented as a left shift followed by an arithmetic right shift.
  function automatic logic signed [MAX_WIDTH-1:0] ext(
    input logic [MAX_WIDTH-1:0] x,
    input logic [SW-1:0]        b
  );
    logic        [SW-1:0]        sh;
    logic signed [MAX_WIDTH-1:0] t;
    if (b == '0 || b > SW'(MAX_WIDTH)) begin
      sh = '0;
    end else begin
      sh = SW'(MAX_WIDTH) - b;
    end
    t = x << sh;
    return t >>> sh;
  endfunction

  // Full-width signed product, then wrapped/extended to the accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
    input logic signed [MAX_WIDTH-1:0] a,
    input logic signed [MAX_WIDTH-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return ACC_WIDTH'(p);
  endfunction

  assign accept    = (state_q == IDLE) && valid_in;
  assign last_step = (state_q == COMPUTE) && (k_q == KW'(K - 1));

  // ready_in is held low while reset is asserted, even though the state
  // register may still read IDLE.
  assign ready_in  = (state_q == IDLE) && rst_ni;
  assign valid_out = (state_q == DONE);
  assign D         = d_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = COMPUTE;
          k_d     = '0;
        end
      end
      COMPUTE: begin
        if (k_q == KW'(K - 1)) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_out) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // One reduction step: every acc[i][j] gains A[i][k]*B[k][j] in parallel.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_d[i][j] = acc_q[i][j] + mul_ext(a_q[i][k_q], b_q[k_q][j]);
      end
    end
  end

  // Control, accumulator and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
          d_q[i][j]   <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          if (accept) begin
            acc_q[i][j] <= accumulate_i ? d_q[i][j] : C_mul[i][j];
          end else if (state_q == COMPUTE) begin
            acc_q[i][j] <= acc_d[i][j];
          end
          if (last_step) begin
            d_q[i][j] <= acc_d[i][j];
          end
        end
      end
    end
  end

  // Operand capture. Operands are stored already precision-extended so the
  // per-step datapath only multiplies; they need no reset because they are
  // always written on accept before being used.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < M; i++) begin
        for (int kk = 0; kk < K; kk++) begin
          a_q[i][kk] <= ext(A_mul[i][kk], bitSizeA);
        end
      end
      for (int kk = 0; kk < K; kk++) begin
        for (int j = 0; j < N; j++) begin
          b_q[kk][j] <= ext(B_mul[kk][j], bitSizeB);
        end
      end
    end
  end

endmodule
